msg_fifo_arbiter: RTL and testbench

Shares the single CPU message FIFO between several on-frame detectors (red/green/blue/obstacle bounding-box writers) inside the image-processing pipeline. Each requester presents a fixed-length message and holds a request. The arbiter grants requesters round-robin and writes each message to the FIFO as one uninterrupted burst. It writes only when the FIFO has room for a whole message, so messages never interleave and are never truncated.

---
 rtl/msg_fifo_arbiter_if.sv | 37 +++
 rtl/msg_fifo_arbiter.sv | 168 ++++++++++++++++
 tb/tb_msg_fifo_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/msg_fifo_arbiter_if.sv
// Handshake and FIFO-write bundle between the on-frame detectors, the
// message arbiter and the CPU message FIFO.
//   req        : level request, one bit per requester
//   req_data   : flattened messages, requester r word w at [(r*MSG_WORDS+w)*32 +: 32]
//   grant      : one-hot grant, high for the whole burst
//   ack        : one-cycle pulse with the last word of a burst
//   busy       : burst in progress
//   fifo_data  : word written to the FIFO
//   fifo_wr    : FIFO write strobe
//   fifo_usedw : FIFO fill level
//   fifo_flush : FIFO synchronous clear pulse
// The master modport is the arbiter side; slave is the requester/FIFO side.
interface msg_fifo_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int MSG_WORDS = 3,
  parameter int USEDW_W   = 8
);
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*MSG_WORDS*32-1:0] req_data;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_REQ-1:0]              ack;
  logic                            busy;
  logic [31:0]                     fifo_data;
  logic                            fifo_wr;
  logic [USEDW_W-1:0]              fifo_usedw;
  logic                            fifo_flush;

  modport master (
    input  req, req_data, fifo_usedw, fifo_flush,
    output grant, ack, busy, fifo_data, fifo_wr
  );

  modport slave (
    output req, req_data, fifo_usedw, fifo_flush,
    input  grant, ack, busy, fifo_data, fifo_wr
  );
endinterface

// File: rtl/msg_fifo_arbiter.sv
// Round-robin arbiter sharing one CPU message FIFO between several detectors.
// Each granted requester has its fixed-length message written as one
// uninterrupted burst, and a burst only starts when the FIFO can take the
// whole message.
// Ports:
//   clk         : pipeline clock
//   reset_n     : asynchronous active-low reset
//   enable      : gates new grants; a running burst always completes
//   bus         : request / grant / FIFO-write bundle (master side)
//   blocked_cnt : saturating count of arbitration cycles lost to a full FIFO
// All outputs are registered.
module msg_fifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MSG_WORDS  = 3,
  parameter int FIFO_DEPTH = 256,
  parameter int USEDW_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  msg_fifo_arbiter_if.master   bus,
  output logic [15:0]          blocked_cnt
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WIDX_W = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(MSG_WORDS - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                wr_q, wr_d;
  logic [31:0]         data_q, data_d;
  logic [15:0]         blk_q, blk_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    prev_last_q, prev_last_d;
  logic [WIDX_W-1:0]   idx_q, idx_d;

  logic                room;
  logic                any_req;
  logic [IDX_W-1:0]    sel;
  logic                found;
  logic [IDX_W:0]      cand;
  logic [WIDX_W-1:0]   nxt_idx;

  function automatic logic [31:0] msg_word(
    input logic [IDX_W-1:0]              r,
    input logic [WIDX_W-1:0]             w,
    input logic [NUM_REQ*MSG_WORDS*32-1:0] d
  );
    return d[(int'(r) * MSG_WORDS + int'(w)) * 32 +: 32];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Room only when a complete message fits; partial messages are never started.
  assign room    = (int'(bus.fifo_usedw) < FIFO_DEPTH - MSG_WORDS);
  assign any_req = |bus.req;
  assign nxt_idx = idx_q + 1'b1;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && bus.req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ack_d       = '0;
    busy_d      = busy_q;
    wr_d        = wr_q;
    data_d      = data_q;
    blk_d       = blk_q;
    last_d      = last_q;
    prev_last_d = prev_last_q;
    idx_d       = idx_q;

    case (state_q)
      IDLE: begin
        if (enable && any_req) begin
          if (!room) begin
            blk_d = sat_inc16(blk_q);
          end else if (!bus.fifo_flush) begin
            state_d     = WRITE;
            grant_d     = NUM_REQ'(1) << sel;
            busy_d      = 1'b1;
            wr_d        = 1'b1;
            data_d      = msg_word(sel, '0, bus.req_data);
            prev_last_d = last_q;
            last_d      = sel;
            idx_d       = '0;
            if (MSG_WORDS == 1) ack_d = NUM_REQ'(1) << sel;
          end
        end
      end

      WRITE: begin
        if (bus.fifo_flush || idx_q == LAST_WORD) begin
          // Burst ends; an aborted burst hands the turn back so the same
          // requester's whole message is reissued.
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          wr_d    = 1'b0;
          data_d  = '0;
          idx_d   = '0;
          if (bus.fifo_flush) last_d = prev_last_q;
        end else begin
          idx_d  = nxt_idx;
          data_d = msg_word(last_q, nxt_idx, bus.req_data);
          if (nxt_idx == LAST_WORD) ack_d = grant_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered outputs / arbitration state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      blk_q       <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      prev_last_q <= IDX_W'(NUM_REQ - 1);
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      blk_q       <= blk_d;
      last_q      <= last_d;
      prev_last_q <= prev_last_d;
      idx_q       <= idx_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.fifo_wr   = wr_q;
  assign bus.fifo_data = data_q;
  assign blocked_cnt   = blk_q;

endmodule

// File: tb/tb_msg_fifo_arbiter.sv
// Directed testbench for msg_fifo_arbiter (4 requesters, 3-word messages,
// 256-word FIFO). Inputs change 1 ns after the rising edge; outputs are
// sampled at the same point.
module tb_msg_fifo_arbiter;
  localparam int NR = 4;
  localparam int MW = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] blocked_cnt;

  int n_chk = 0;
  int n_err = 0;

  msg_fifo_arbiter_if #(.NUM_REQ(NR), .MSG_WORDS(MW), .USEDW_W(8)) bus_if ();

  msg_fifo_arbiter #(
    .NUM_REQ(NR), .MSG_WORDS(MW), .FIFO_DEPTH(256), .USEDW_W(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .bus        (bus_if),
    .blocked_cnt(blocked_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wexp(input int r, input int w);
    return 32'hC0DE_0000 + 32'(r * 16 + w);
  endfunction

  task automatic do_reset();
    reset_n            = 1'b0;
    enable             = 1'b1;
    bus_if.req         = '0;
    bus_if.fifo_usedw  = '0;
    bus_if.fifo_flush  = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  // One full burst of requester r starting at the next edge; req is set to
  // req_after during the ack cycle.
  task automatic expect_burst(input int r, input logic [NR-1:0] req_after);
    tick();
    check_val("grant_w0", 32'(bus_if.grant), 32'(1 << r));
    check_val("busy_w0",  32'(bus_if.busy), 32'd1);
    check_val("wr_w0",    32'(bus_if.fifo_wr), 32'd1);
    check_val("data_w0",  bus_if.fifo_data, wexp(r, 0));
    check_val("ack_w0",   32'(bus_if.ack), 32'd0);
    tick();
    check_val("data_w1",  bus_if.fifo_data, wexp(r, 1));
    check_val("ack_w1",   32'(bus_if.ack), 32'd0);
    tick();
    check_val("data_w2",  bus_if.fifo_data, wexp(r, 2));
    check_val("wr_w2",    32'(bus_if.fifo_wr), 32'd1);
    check_val("ack_w2",   32'(bus_if.ack), 32'(1 << r));
    bus_if.req = req_after;
    tick();
    check_val("grant_idle", 32'(bus_if.grant), 32'd0);
    check_val("busy_idle",  32'(bus_if.busy), 32'd0);
    check_val("wr_idle",    32'(bus_if.fifo_wr), 32'd0);
    check_val("ack_idle",   32'(bus_if.ack), 32'd0);
  endtask

  initial begin
    for (int r = 0; r < NR; r++)
      for (int w = 0; w < MW; w++)
        bus_if.req_data[(r*MW+w)*32 +: 32] = wexp(r, w);

    // Reset values
    do_reset();
    check_val("rst_grant", 32'(bus_if.grant), 32'd0);
    check_val("rst_ack",   32'(bus_if.ack), 32'd0);
    check_val("rst_busy",  32'(bus_if.busy), 32'd0);
    check_val("rst_wr",    32'(bus_if.fifo_wr), 32'd0);
    check_val("rst_data",  bus_if.fifo_data, 32'd0);
    check_val("rst_blk",   32'(blocked_cnt), 32'd0);

    // Single request from requester 1
    bus_if.req = 4'b0010;
    expect_burst(1, 4'b0000);

    // Round robin with all requests held: 0,1,2,3,0 with one idle cycle between
    do_reset();
    bus_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) expect_burst(k % NR, 4'b1111);
    bus_if.req = '0;
    tick();

    // Full FIFO: blocked counting, then grant once room appears
    do_reset();
    bus_if.fifo_usedw = 8'd253;
    bus_if.req = 4'b0001;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_val("blk_cnt",   32'(blocked_cnt), 32'(i));
      check_val("blk_wr",    32'(bus_if.fifo_wr), 32'd0);
      check_val("blk_grant", 32'(bus_if.grant), 32'd0);
    end
    bus_if.fifo_usedw = 8'd252;
    expect_burst(0, 4'b0000);
    check_val("blk_hold", 32'(blocked_cnt), 32'd3);

    // Saturation of blocked_cnt
    do_reset();
    bus_if.fifo_usedw = 8'd253;
    bus_if.req = 4'b0001;
    tick(65534);
    check_val("blk_fffe", 32'(blocked_cnt), 32'h0000_FFFE);
    tick();
    check_val("blk_ffff", 32'(blocked_cnt), 32'h0000_FFFF);
    tick(3);
    check_val("blk_sat",  32'(blocked_cnt), 32'h0000_FFFF);

    // Flush in the second word cycle: abort, turn handed back, full reissue
    do_reset();
    bus_if.req = 4'b0101;
    tick();
    check_val("fl_grant", 32'(bus_if.grant), 32'b0001);
    check_val("fl_d0",    bus_if.fifo_data, wexp(0, 0));
    tick();
    check_val("fl_d1",    bus_if.fifo_data, wexp(0, 1));
    bus_if.fifo_flush = 1'b1;
    tick();
    check_val("fl_wr",    32'(bus_if.fifo_wr), 32'd0);
    check_val("fl_grant0",32'(bus_if.grant), 32'd0);
    check_val("fl_ack",   32'(bus_if.ack), 32'd0);
    check_val("fl_busy",  32'(bus_if.busy), 32'd0);
    tick();
    check_val("fl_idle_nogrant", 32'(bus_if.grant), 32'd0);
    bus_if.fifo_flush = 1'b0;
    expect_burst(0, 4'b0100);
    expect_burst(2, 4'b0000);

    // Asynchronous reset in the middle of a burst
    do_reset();
    bus_if.req = 4'b0010;
    tick();
    check_val("rm_grant", 32'(bus_if.grant), 32'b0010);
    tick();
    reset_n = 1'b0;
    #1;
    check_val("rm_grant0", 32'(bus_if.grant), 32'd0);
    check_val("rm_busy",   32'(bus_if.busy), 32'd0);
    check_val("rm_wr",     32'(bus_if.fifo_wr), 32'd0);
    check_val("rm_data",   bus_if.fifo_data, 32'd0);
    check_val("rm_ack",    32'(bus_if.ack), 32'd0);
    bus_if.req = 4'b1111;
    tick();
    reset_n = 1'b1;
    expect_burst(0, 4'b0000);

    // Enable low blocks grants but not a running burst
    do_reset();
    enable = 1'b0;
    bus_if.req = 4'b0100;
    tick(3);
    check_val("en_nogrant", 32'(bus_if.grant), 32'd0);
    check_val("en_nobusy",  32'(bus_if.busy), 32'd0);
    check_val("en_noblk",   32'(blocked_cnt), 32'd0);
    enable = 1'b1;
    tick();
    check_val("en_grant", 32'(bus_if.grant), 32'b0100);
    enable = 1'b0;
    tick();
    check_val("en_d1",  bus_if.fifo_data, wexp(2, 1));
    tick();
    check_val("en_d2",  bus_if.fifo_data, wexp(2, 2));
    check_val("en_ack", 32'(bus_if.ack), 32'b0100);
    bus_if.req = '0;
    tick();
    check_val("en_done", 32'(bus_if.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
